fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The module SHALL have parameter DEPTH, default 2, giving the number of fetch-buffer entries.
REQ-003 Port CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port RESETn, input, 1: reset, asynchronous and active-low.
REQ-005 Port IMemAddr, output, 32: byte address to the instruction memory; equals the PC register.
REQ-006 Port IMemInstr, input, 32: instruction word returned combinationally by the instruction memory for IMemAddr.
REQ-007 Port BranchTaken, input, 1: redirect request from execute.
REQ-008 Port BranchTarget, input, 32: redirect byte address.
REQ-009 Port Halt, input, 1: freezes fetching while high.
REQ-010 Port F_Valid, output, 1: buffer head holds a valid instruction.
REQ-011 Port F_Ready, input, 1: decode accepts the head this cycle.
REQ-012 Port F_Instr, output, 32: instruction at the buffer head.
REQ-013 Port F_PC, output, 32: fetch address of the head.
REQ-014 Port F_PCPlus8, output, 32: F_PC + 8, the architectural PC read value.

Function
REQ-015 The PC register SHALL always hold a word-aligned address; BranchTarget[1:0] SHALL be forced to 0 on load.
REQ-016 The FSM SHALL have states BOOT, RUN, HALT; reset enters BOOT.
REQ-017 BOOT SHALL last exactly one cycle with no push, then go to RUN (or HALT if Halt=1).
REQ-018 RUN -> HALT when Halt=1; HALT -> RUN when Halt=0; BranchTaken is honoured in every state except BOOT.
REQ-019 In RUN a push SHALL occur when count < DEPTH, or when count == DEPTH and a pop occurs the same cycle.
REQ-020 A push SHALL write {IMemAddr, IMemInstr} to the buffer tail and increment PC by 4, wrapping modulo 2^32.
REQ-021 A pop SHALL occur when F_Valid and F_Ready are both 1, removing the head.
REQ-022 F_Valid SHALL equal (count != 0); F_Instr, F_PC and F_PCPlus8 SHALL be driven combinationally from the head.
REQ-023 When F_Valid=0, F_Instr, F_PC and F_PCPlus8 SHALL be 0.
REQ-024 BranchTaken=1 SHALL flush the buffer (count := 0) and load PC := BranchTarget. Push and pop SHALL be suppressed that cycle, and F_Valid SHALL be 0 the next cycle.
REQ-025 BranchTaken SHALL take priority over Halt, push and pop in the same cycle.
REQ-026 In HALT no push SHALL occur and PC SHALL hold; the buffer SHALL continue to drain via pops.
REQ-027 Latency: an instruction pushed at edge N SHALL be visible on F_Instr after edge N when the buffer was empty.
REQ-028 Ordering SHALL be FIFO; the count SHALL never exceed DEPTH or underflow.

Reset
REQ-029 Asserting RESETn low SHALL immediately set PC := RESET_PC, count := 0, read/write pointers := 0, and state := BOOT, regardless of the clock.
REQ-030 During reset F_Valid SHALL be 0, IMemAddr SHALL be RESET_PC, and F_Instr/F_PC/F_PCPlus8 SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard buffered instructions; nothing is popped after release until a new push.
REQ-032 Buffer storage contents need not be reset; only valid tracking is reset.

Structure
REQ-033 Shared package SHALL hold the FSM state encoding, the 32-bit word width constant, and the PC-increment (4) and PC-read offset (8) constants.
REQ-034 The buffer SHALL be a sub-module fetch_fifo (DEPTH entries of 64 bits, push/pop/flush, count output); the PC and FSM remain in fetch_stage.

Verification
REQ-035 Reset release with F_Ready=1 and memory words 0:E59F1204, 1:E59F9204 -> no push in the BOOT cycle; then F_PC = 0, 4, 8 on consecutive cycles; F_PCPlus8 = 8 when F_PC = 0.
REQ-036 F_Ready=0 for 5 cycles -> count saturates at 2, PC stops at RESET_PC+8, and F_Instr holds the word at address 0; raising F_Ready -> heads 0 then 4, no loss or duplication.
REQ-037 BranchTaken=1 with BranchTarget=32'h0000_0023 while the buffer is full -> next cycle F_Valid=0 and IMemAddr=32'h20; the following cycle F_PC=32'h20.
REQ-038 Halt=1 for 3 cycles with F_Ready=1 -> buffer drains to F_Valid=0 and PC holds; Halt=0 -> fetching resumes at the held PC.
REQ-039 RESET_PC=32'hFFFF_FFFC -> second push has F_PC=0 (wrap).
REQ-040 RESETn pulsed low asynchronously mid-stream with the buffer full -> F_Valid drops before the next edge; after release, fetching restarts from RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the fetch stage.
// FSM encoding, word width, PC offsets, buffer entry.
package fetch_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] PC_INC    = 32'd4;
  localparam logic [XLEN-1:0] PC_RD_OFS = 32'd8;
  localparam logic [XLEN-1:0] PC_MASK   = 32'hFFFF_FFFC;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH x 64-bit FIFO with push/pop/flush.
// Ports: clk, rst_n, flush, push, pop, wdata, rdata (head), count.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [CW-1:0] count
);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   wp;
  logic [PW-1:0]   rp;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage is not reset; only pointers/count track validity.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wp] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= nxt(wp);
      if (pop)  rp <= nxt(rp);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rp];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, BOOT/RUN/HALT FSM, fetch buffer.
// Ports: CLK, RESETn, IMem*, BranchTaken/Target, Halt, F_* handshake.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic            CLK,
  input  logic            RESETn,
  output logic [XLEN-1:0] IMemAddr,
  input  logic [XLEN-1:0] IMemInstr,
  input  logic            BranchTaken,
  input  logic [XLEN-1:0] BranchTarget,
  input  logic            Halt,
  output logic            F_Valid,
  input  logic            F_Ready,
  output logic [XLEN-1:0] F_Instr,
  output logic [XLEN-1:0] F_PC,
  output logic [XLEN-1:0] F_PCPlus8
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [1:0]      state;
  logic [1:0]      state_n;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_n;
  logic [CW-1:0]   count;
  fetch_entry_t    head;
  fetch_entry_t    tail;
  logic            flush;
  logic            push;
  logic            pop;
  logic            f_valid;

  // Redirects are ignored while booting.
  assign flush   = BranchTaken && (state != ST_BOOT);
  assign f_valid = (count != '0);
  assign pop     = f_valid && F_Ready && !flush;
  // Full buffer may still accept when the head leaves this cycle.
  assign push    = (state == ST_RUN) && !flush
                && ((count < CW'(DEPTH)) || pop);

  assign tail = '{pc: pc, instr: IMemInstr};

  always_comb begin
    state_n = state;
    unique case (state)
      ST_BOOT,
      ST_RUN,
      ST_HALT: state_n = Halt ? ST_HALT : ST_RUN;
      default: state_n = ST_BOOT;
    endcase
  end

  always_comb begin
    pc_n = pc;
    unique case (1'b1)
      flush:   pc_n = BranchTarget & PC_MASK;
      push:    pc_n = pc + PC_INC;
      default: pc_n = pc;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= ST_BOOT;
      pc    <= RESET_PC & PC_MASK;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESETn),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (tail),
    .rdata (head),
    .count (count)
  );

  assign IMemAddr  = pc;
  assign F_Valid   = f_valid;
  assign F_Instr   = f_valid ? head.instr : '0;
  assign F_PC      = f_valid ? head.pc : '0;
  assign F_PCPlus8 = f_valid ? head.pc + PC_RD_OFS : '0;

endmodule
